// File: rtl/knn_distance_feeder.sv
// knn_distance_feeder: streams candidate points, computes the saturated squared
// distance to a latched query and keeps an external k-entry queue holding the
// K closest points (insert while not full, evict-largest-then-insert when the
// new distance is strictly smaller than the queue's max tag, otherwise drop).
//
// Ports:
//   clk_in / rst_in            clock, asynchronous active-low reset
//   start_in, query_*_in       start a query and sample its point (ignored while busy)
//   pt_valid_in / pt_ready_out candidate handshake (ready only in ACCEPT)
//   pt_x_in, pt_y_in, pt_id_in candidate coordinates and identifier
//   pt_last_in                 candidate is the final one of the query
//   q_enq_out, q_enq_*_out     enqueue pulse with id/distance to the queue
//   q_deq_largest_out          evict-largest pulse to the queue
//   q_full_in, q_max_tag_in    queue status, trusted only after settling
//   busy_out, done_out         query in progress / last point fully processed
//   inserted_count_out, dropped_count_out  per-query statistics (wrap mod 2^16)
module knn_distance_feeder #(
    parameter int COORD_WIDTH   = 16,
    parameter int ID_WIDTH      = 32,
    parameter int TAG_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [COORD_WIDTH-1:0] query_x_in,
    input  logic [COORD_WIDTH-1:0] query_y_in,
    input  logic                   pt_valid_in,
    output logic                   pt_ready_out,
    input  logic [COORD_WIDTH-1:0] pt_x_in,
    input  logic [COORD_WIDTH-1:0] pt_y_in,
    input  logic [ID_WIDTH-1:0]    pt_id_in,
    input  logic                   pt_last_in,
    output logic                   q_enq_out,
    output logic [ID_WIDTH-1:0]    q_enq_data_out,
    output logic [TAG_WIDTH-1:0]   q_enq_tag_out,
    output logic                   q_deq_largest_out,
    input  logic                   q_full_in,
    input  logic [TAG_WIDTH-1:0]   q_max_tag_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [15:0]            inserted_count_out,
    output logic [15:0]            dropped_count_out
);
    localparam int FULL_W = 2 * COORD_WIDTH + 1;
    // At least one bit above the tag so saturation can always be detected.
    localparam int SUM_W  = (FULL_W > TAG_WIDTH) ? FULL_W : TAG_WIDTH + 1;
    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ACCEPT, S_DIFF, S_DIST, S_DECIDE,
        S_EVICT, S_EVICT_WAIT, S_INSERT, S_SETTLE, S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [COORD_WIDTH-1:0] r_qx, r_qy, r_px, r_py, r_dx, r_dy;
    logic [ID_WIDTH-1:0]    r_id;
    logic                   r_last;
    logic [TAG_WIDTH-1:0]   r_dist;
    logic [WAIT_W-1:0]      r_wait;
    logic [ID_WIDTH-1:0]    r_enq_data;
    logic [TAG_WIDTH-1:0]   r_enq_tag;
    logic [15:0]            r_ins, r_drop;
    logic [COORD_WIDTH-1:0] w_dx, w_dy;
    logic [SUM_W-1:0]       w_sum;
    logic                   w_sat, w_wait_done, w_drop, w_waiting;

    assign w_dx        = (r_px >= r_qx) ? r_px - r_qx : r_qx - r_px;
    assign w_dy        = (r_py >= r_qy) ? r_py - r_qy : r_qy - r_py;
    assign w_sum       = SUM_W'(r_dx) * SUM_W'(r_dx) + SUM_W'(r_dy) * SUM_W'(r_dy);
    assign w_sat       = |w_sum[SUM_W-1:TAG_WIDTH];
    assign w_wait_done = (r_wait == WAIT_W'(SETTLE_CYCLES - 1));
    // EVICT_WAIT and SETTLE share one counter; it restarts on every state entry.
    assign w_waiting   = (r_state == w_next) && (r_state == S_EVICT_WAIT || r_state == S_SETTLE);

    always_comb begin
        w_next = r_state;
        w_drop = 1'b0;
        case (r_state)
            S_IDLE:       w_next = start_in ? S_ACCEPT : S_IDLE;
            S_ACCEPT:     w_next = pt_valid_in ? S_DIFF : S_ACCEPT;
            S_DIFF:       w_next = S_DIST;
            S_DIST:       w_next = S_DECIDE;
            S_DECIDE: begin
                // A tie with the max tag keeps the earlier point.
                if (!q_full_in) w_next = S_INSERT;
                else if (r_dist < q_max_tag_in) w_next = S_EVICT;
                else begin
                    w_drop = 1'b1;
                    w_next = r_last ? S_DONE : S_ACCEPT;
                end
            end
            S_EVICT:      w_next = S_EVICT_WAIT;
            S_EVICT_WAIT: w_next = w_wait_done ? S_INSERT : S_EVICT_WAIT;
            S_INSERT:     w_next = S_SETTLE;
            S_SETTLE:     w_next = w_wait_done ? (r_last ? S_DONE : S_ACCEPT) : S_SETTLE;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_qx       <= '0;
            r_qy       <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_id       <= '0;
            r_last     <= 1'b0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_dist     <= '0;
            r_wait     <= '0;
            r_enq_data <= '0;
            r_enq_tag  <= '0;
            r_ins      <= '0;
            r_drop     <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_waiting ? r_wait + 1'b1 : '0;
            if (r_state == S_IDLE && start_in) begin
                r_qx   <= query_x_in;
                r_qy   <= query_y_in;
                r_ins  <= '0;
                r_drop <= '0;
            end
            if (r_state == S_ACCEPT && pt_valid_in) begin
                r_px   <= pt_x_in;
                r_py   <= pt_y_in;
                r_id   <= pt_id_in;
                r_last <= pt_last_in;
            end
            if (r_state == S_DIFF) begin
                r_dx <= w_dx;
                r_dy <= w_dy;
            end
            if (r_state == S_DIST) r_dist <= w_sat ? '1 : w_sum[TAG_WIDTH-1:0];
            // Load the enqueue payload on entry so it is valid during the pulse.
            if (w_next == S_INSERT && r_state != S_INSERT) begin
                r_enq_data <= r_id;
                r_enq_tag  <= r_dist;
            end
            if (r_state == S_INSERT) r_ins <= r_ins + 16'd1;
            if (w_drop) r_drop <= r_drop + 16'd1;
        end
    end

    assign pt_ready_out       = (r_state == S_ACCEPT);
    assign q_enq_out          = (r_state == S_INSERT);
    assign q_deq_largest_out  = (r_state == S_EVICT);
    assign busy_out           = (r_state != S_IDLE);
    assign done_out           = (r_state == S_DONE);
    assign q_enq_data_out     = r_enq_data;
    assign q_enq_tag_out      = r_enq_tag;
    assign inserted_count_out = r_ins;
    assign dropped_count_out  = r_drop;
endmodule

// File: tb/tb_knn_distance_feeder.sv
// tb_knn_distance_feeder: randomized scoreboard bench with a K-closest reference model and a queue model.
module tb_knn_distance_feeder;
    localparam int K = 4;

    typedef struct {
        bit          deq;
        logic [31:0] id;
        logic [31:0] tag;
        int          lat;
    } ev_t;

    logic        clk = 1'b0, clk_en = 1'b1, rst_in = 1'b0;
    logic        start_in = 1'b0, pt_valid_in = 1'b0, pt_last_in = 1'b0;
    logic [15:0] query_x_in = '0, query_y_in = '0, pt_x_in = '0, pt_y_in = '0;
    logic [31:0] pt_id_in = '0;
    logic        pt_ready_out, q_enq_out, q_deq_largest_out, busy_out, done_out;
    logic [31:0] q_enq_data_out, q_enq_tag_out;
    logic        env_full = 1'b0;
    logic [31:0] env_max = '0;
    logic [15:0] inserted_count_out, dropped_count_out;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, hs_cyc = 0;
    int cur_qx, cur_qy, ref_ins, ref_drop;
    ev_t exp_q[$];
    ev_t me;
    longint unsigned env_q[$];
    longint unsigned mdl_q[$];

    knn_distance_feeder dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
        .query_x_in(query_x_in), .query_y_in(query_y_in),
        .pt_valid_in(pt_valid_in), .pt_ready_out(pt_ready_out),
        .pt_x_in(pt_x_in), .pt_y_in(pt_y_in), .pt_id_in(pt_id_in), .pt_last_in(pt_last_in),
        .q_enq_out(q_enq_out), .q_enq_data_out(q_enq_data_out), .q_enq_tag_out(q_enq_tag_out),
        .q_deq_largest_out(q_deq_largest_out), .q_full_in(env_full), .q_max_tag_in(env_max),
        .busy_out(busy_out), .done_out(done_out),
        .inserted_count_out(inserted_count_out), .dropped_count_out(dropped_count_out)
    );

    always #5 clk = clk_en ? ~clk : clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int argmax(input longint unsigned q[$]);
        int m = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] > q[m]) m = i;
        return m;
    endfunction

    // Queue model driven by the DUT's pulses; it is the environment, not the reference.
    initial forever begin
        @(negedge clk or negedge rst_in);
        if (!rst_in) env_q.delete();
        else begin
            if (q_deq_largest_out && env_q.size() > 0) env_q.delete(argmax(env_q));
            if (q_enq_out) env_q.push_back(longint'(q_enq_tag_out));
        end
        env_full = (env_q.size() >= K);
        env_max  = (env_q.size() > 0) ? 32'(env_q[argmax(env_q)]) : 32'd0;
    end

    // Monitor: pop and compare every queue pulse against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_in) begin
            chk("enq_deq_overlap", longint'(q_enq_out & q_deq_largest_out), 0);
            if (q_deq_largest_out) begin
                chk("deq_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    me = exp_q.pop_front();
                    chk("deq_kind", me.deq, 1);
                    chk("deq_cycle", cyc - hs_cyc, me.lat);
                end
            end
            if (q_enq_out) begin
                chk("enq_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    me = exp_q.pop_front();
                    chk("enq_kind", me.deq, 0);
                    chk("enq_cycle", cyc - hs_cyc, me.lat);
                    chk("enq_data", q_enq_data_out, me.id);
                    chk("enq_tag", q_enq_tag_out, me.tag);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b0;
        mdl_q.delete();
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_q(input int qx, input int qy);
        @(negedge clk);
        start_in = 1'b1;
        query_x_in = 16'(qx);
        query_y_in = 16'(qy);
        @(negedge clk);
        start_in = 1'b0;
        cur_qx = qx;
        cur_qy = qy;
        ref_ins = 0;
        ref_drop = 0;
        chk("start_busy", busy_out, 1);
        chk("start_ready", pt_ready_out, 1);
        chk("start_ins_cnt", inserted_count_out, 0);
        chk("start_drop_cnt", dropped_count_out, 0);
    endtask

    task automatic send_pt(input int x, input int y, input logic [31:0] id, input bit last,
                           input bit inject, input int gap);
        int dx, dy, rlat, m;
        bit got;
        longint unsigned d;
        dx = (x > cur_qx) ? x - cur_qx : cur_qx - x;
        dy = (y > cur_qy) ? y - cur_qy : cur_qy - y;
        d  = longint'(dx) * dx + longint'(dy) * dy;
        if (d > 64'hFFFF_FFFF) d = 64'hFFFF_FFFF;
        if (mdl_q.size() < K) begin
            exp_q.push_back('{1'b0, id, 32'(d), 4});
            mdl_q.push_back(d);
            ref_ins++;
            rlat = 7;
        end else begin
            m = argmax(mdl_q);
            if (d < mdl_q[m]) begin
                mdl_q.delete(m);
                mdl_q.push_back(d);
                exp_q.push_back('{1'b1, 32'd0, 32'd0, 4});
                exp_q.push_back('{1'b0, id, 32'(d), 7});
                ref_ins++;
                rlat = 10;
            end else begin
                ref_drop++;
                rlat = 4;
            end
        end
        repeat (gap) @(negedge clk);
        pt_valid_in = 1'b1;
        pt_x_in = 16'(x);
        pt_y_in = 16'(y);
        pt_id_in = id;
        pt_last_in = last;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pt_ready_out) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("handshake_timeout", got, 1);
        if (!got) begin
            pt_valid_in = 1'b0;
            return;
        end
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        pt_valid_in = 1'b0;
        pt_x_in = 16'($urandom);
        pt_y_in = 16'($urandom);
        pt_id_in = $urandom;
        pt_last_in = 1'b0;
        if (inject) begin
            start_in = 1'b1;
            query_x_in = 16'd0;
            query_y_in = 16'd0;
            @(posedge clk);
            #1;
            start_in = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (last ? done_out : pt_ready_out) begin
                got = 1'b1;
                break;
            end
        end
        chk(last ? "done_timeout" : "ready_timeout", got, 1);
        if (got) chk(last ? "done_cycle" : "ready_cycle", cyc - hs_cyc, rlat);
        chk("ins_cnt", inserted_count_out, ref_ins);
        chk("drop_cnt", dropped_count_out, ref_drop);
        if (last) begin
            @(negedge clk);
            chk("done_single_pulse", done_out, 0);
            chk("busy_after_done", busy_out, 0);
        end
    endtask

    task automatic final_cmp();
        longint unsigned a[$];
        a = env_q;
        a.sort();
        mdl_q.sort();
        chk("sb_empty", exp_q.size(), 0);
        chk("queue_size", a.size(), mdl_q.size());
        if (a.size() == mdl_q.size())
            for (int i = 0; i < a.size(); i++) chk("queue_tag", longint'(a[i]), longint'(mdl_q[i]));
    endtask

    initial begin
        int qx, qy, x, y;
        bit big;
        repeat (3) @(negedge clk);
        chk("rst_ready", pt_ready_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_enq", q_enq_out, 0);
        rst_in = 1'b1;
        @(negedge clk);
        chk("idle_ready", pt_ready_out, 0);
        chk("idle_ins_cnt", inserted_count_out, 0);

        // Plain insert, then asynchronous reset with the clock stopped.
        start_q(10, 10);
        send_pt(13, 14, 32'd5, 1'b0, 1'b0, 0);
        clk_en = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_ready", pt_ready_out, 0);
        chk("arst_busy", busy_out, 0);
        chk("arst_done", done_out, 0);
        chk("arst_enq", q_enq_out, 0);
        chk("arst_deq", q_deq_largest_out, 0);
        chk("arst_enq_data", q_enq_data_out, 0);
        chk("arst_enq_tag", q_enq_tag_out, 0);
        chk("arst_ins_cnt", inserted_count_out, 0);
        chk("arst_drop_cnt", dropped_count_out, 0);
        mdl_q.delete();
        #2;
        rst_in = 1'b1;
        #1;
        clk_en = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", pt_ready_out, 0);
        chk("post_rst_busy", busy_out, 0);
        chk("post_rst_sb_empty", exp_q.size(), 0);

        // Fill to max tag 100, then a tie (dropped) and a closer point (evict+insert).
        start_q(10, 10);
        send_pt(20, 10, 32'd100, 1'b0, 1'b0, 0);
        send_pt(11, 10, 32'd101, 1'b0, 1'b0, 1);
        send_pt(12, 10, 32'd102, 1'b0, 1'b0, 0);
        send_pt(13, 10, 32'd103, 1'b0, 1'b0, 2);
        send_pt(10, 20, 32'd7, 1'b0, 1'b0, 0);
        send_pt(12, 13, 32'd9, 1'b1, 1'b0, 0);
        final_cmp();

        // Saturating distance.
        do_reset();
        start_q(0, 0);
        send_pt(65535, 65535, 32'd77, 1'b1, 1'b0, 0);
        final_cmp();

        // Three points with a start pulse mid-stream that must be ignored.
        do_reset();
        start_q(100, 50);
        send_pt(103, 54, 32'd1, 1'b0, 1'b0, 0);
        send_pt(90, 40, 32'd2, 1'b0, 1'b1, 0);
        send_pt(100, 51, 32'd3, 1'b1, 1'b0, 1);
        final_cmp();

        // Randomized queries with many ties, evictions and occasional saturation.
        for (int qn = 0; qn < 4; qn++) begin
            do_reset();
            qx = $urandom_range(50, 65000);
            qy = $urandom_range(50, 65000);
            start_q(qx, qy);
            for (int p = 0; p < 25; p++) begin
                big = ($urandom_range(0, 7) == 0);
                x = big ? int'($urandom_range(0, 65535)) : qx + int'($urandom_range(0, 12)) - 6;
                y = big ? int'($urandom_range(0, 65535)) : qy + int'($urandom_range(0, 12)) - 6;
                send_pt(x, y, $urandom, p == 24, 1'b0, int'($urandom_range(0, 2)));
            end
            final_cmp();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/knn_distance_feeder.md
Name: knn_distance_feeder

Overview:
- Upstream stage of the k-nearest priority queue. Latches a 2-D query point and accepts a stream of candidate points over a ready/valid handshake.
- For each point it computes the saturated squared Euclidean distance to the query.
- It keeps the queue holding the K closest points: insert while the queue is not full, otherwise evict-largest-then-insert only when the new distance is strictly smaller than the queue's max tag.
- The queue's contents are the k-NN result for the query.

Parameters:
- COORD_WIDTH, 16, unsigned width of each coordinate.
- ID_WIDTH, 32, point identifier width; matches the queue's data width.
- TAG_WIDTH, 32, distance width; matches the queue's tag width.
- SETTLE_CYCLES, 2, wait after any queue enq/deq before its full/max/size outputs are trusted.

Ports:
- clk_in  in  1  single clock.
- rst_in  in  1  asynchronous, active-low reset.
- start_in  in  1  one-cycle pulse; latch query, clear counters; ignored while busy_out=1.
- query_x_in, query_y_in  in  COORD_WIDTH each  query point, sampled on start_in.
- pt_valid_in  in  1  candidate valid.
- pt_ready_out  out  1  feeder can accept a candidate.
- pt_x_in, pt_y_in  in  COORD_WIDTH each  candidate coordinates.
- pt_id_in  in  ID_WIDTH  candidate identifier.
- pt_last_in  in  1  candidate is the final one of the query.
- q_enq_out  out  1  enqueue pulse to the queue.
- q_enq_data_out  out  ID_WIDTH  enqueued id.
- q_enq_tag_out  out  TAG_WIDTH  enqueued distance.
- q_deq_largest_out  out  1  evict-largest pulse to the queue.
- q_full_in  in  1  queue full.
- q_max_tag_in  in  TAG_WIDTH  largest tag currently in the queue.
- busy_out  out  1  query in progress.
- done_out  out  1  one-cycle pulse when the last point has been fully processed.
- inserted_count_out, dropped_count_out  out  16 each  per-query statistics; wrap modulo 2^16.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - Every output goes to 0, the FSM goes to IDLE, and the query/point registers and counters are cleared.
  - No clock is needed for this to take effect.
  - The queue is reset from the same source; no partial enq/deq pulse survives reset.
- States: IDLE, ACCEPT, DIFF, DIST, DECIDE, EVICT, EVICT_WAIT, INSERT, SETTLE, DONE.
- IDLE:
  - On start_in: latch the query, zero both counters, set busy_out=1, go to ACCEPT.
- ACCEPT:
  - pt_ready_out=1 here only.
  - On pt_valid_in&&pt_ready_out (handshake edge = cycle 0): latch x, y, id and last; go to DIFF.
  - Exactly one point is in flight at a time.
- DIFF (cycle 1):
  - Register |pt_x-query_x| and |pt_y-query_y| (COORD_WIDTH each, computed without wrap).
- DIST (cycle 2):
  - dist = dx^2+dy^2 at full width 2*COORD_WIDTH+1.
  - If the result exceeds TAG_WIDTH bits, the tag saturates to all-ones.
  - Register the result.
- DECIDE (cycle 3), using q_full_in and q_max_tag_in sampled this cycle:
  - q_full_in=0: go to INSERT.
  - q_full_in=1 and dist<q_max_tag_in: go to EVICT.
  - Otherwise the point is dropped, including the tie dist==max (the earlier point is kept):
    - dropped_count +1.
    - Go to DONE if last, else ACCEPT.
- EVICT (cycle 4):
  - q_deq_largest_out=1 for exactly one cycle.
  - Go to EVICT_WAIT for 2 cycles (cycles 5-6) while the freed slot is recycled, then INSERT.
- INSERT (cycle 4 without eviction, cycle 7 with eviction):
  - q_enq_out=1 for exactly one cycle, with q_enq_data_out=id and q_enq_tag_out=dist.
  - inserted_count +1.
  - Go to SETTLE.
  - q_enq_data_out and q_enq_tag_out hold their values until the next INSERT.
- SETTLE:
  - Hold for SETTLE_CYCLES cycles, then go to DONE if last, else ACCEPT.
  - pt_ready_out therefore reasserts at cycle 7 (plain insert) or cycle 10 (evict+insert). A dropped point is followed by ACCEPT at cycle 4.
- DONE:
  - done_out=1 for one cycle, busy_out returns to 0, go to IDLE.
- Ordering: q_enq_out and q_deq_largest_out are never asserted in the same cycle. A new evict/insert never happens before a prior enq/deq has settled.
- start_in while busy, and pt_valid_in outside ACCEPT, have no effect; pt_ready_out=0 applies backpressure.
- Clearing the queue between queries is the integrator's job (reset); the feeder assumes the queue holds only the current query's points.

Test Plan:
1. Hold rst_in=0 mid-run with no clock edges -> every output 0 immediately. After release: IDLE, pt_ready_out=0, both counters 0.
2. start_in with query (10,10), then point id=5 at (13,14), q_full_in=0 -> q_enq_out pulse at cycle 4 with tag 25 and data 5. inserted_count_out=1. pt_ready_out high again at cycle 7.
3. q_full_in=1, q_max_tag_in=100, point (10,20) (dist 100, tie) -> no enq and no deq. dropped_count_out=1. pt_ready_out high at cycle 4.
4. q_full_in=1, q_max_tag_in=100, point id=9 at (12,13) (dist 13) -> q_deq_largest_out pulse at cycle 4. q_enq_out at cycle 7 with tag 13 and data 9, never overlapping the deq pulse.
5. Query (0,0), point (65535,65535) -> raw sum 8589672450 exceeds 32 bits -> tag 0xFFFFFFFF.
6. Three points with pt_last_in set on the third; start_in pulsed mid-stream -> the start is ignored. done_out is a single-cycle pulse after the third point's SETTLE, and busy_out is 0 on the following cycle.
